// File: rtl/icache_dm_param_if.sv
// Fetch-side and refill-side bus of icache_dm_param.
// The slave modport is the cache; the master modport is the CPU and memory side.
interface icache_dm_param_if #(
    parameter int WORD_SIZE      = 16,
    parameter int WORDS_PER_LINE = 4
);
    logic                                cpu_read;
    logic [WORD_SIZE-1:0]                cpu_addr;
    logic [WORD_SIZE-1:0]                cpu_data;
    logic                                cpu_ready;
    logic                                mem_read;
    logic [WORD_SIZE-1:0]                mem_addr;
    logic [WORD_SIZE*WORDS_PER_LINE-1:0] mem_data;
    logic                                mem_ready;

    modport master (
        output cpu_read, cpu_addr, mem_data, mem_ready,
        input  cpu_data, cpu_ready, mem_read, mem_addr
    );

    modport slave (
        input  cpu_read, cpu_addr, mem_data, mem_ready,
        output cpu_data, cpu_ready, mem_read, mem_addr
    );
endinterface

// File: rtl/icache_dm_param.sv
// Direct-mapped instruction cache with 0-cycle hits, line-wide refill and flash invalidate.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_dm_param #(
    parameter int WORD_SIZE      = 16,
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int STAT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    icache_dm_param_if.slave       bus,
    input  logic                   invalidate
`ifdef ICACHE_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]  hit_count,
    output logic [STAT_WIDTH-1:0]  miss_count
`endif
);
    localparam int OFF = $clog2(WORDS_PER_LINE);
    localparam int IDX = $clog2(NUM_LINES);
    localparam int TAG = WORD_SIZE - IDX - OFF;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                state;
    logic [WORD_SIZE-1:0]  data_arr [NUM_LINES][WORDS_PER_LINE];
    logic [TAG-1:0]        tag_arr  [NUM_LINES];
    logic [NUM_LINES-1:0]  valid;
    logic                  inv_pending;

    logic [OFF-1:0]        offset;
    logic [IDX-1:0]        index;
    logic [TAG-1:0]        tag;
    logic                  hit;
    logic                  miss;

    assign offset = bus.cpu_addr[OFF-1:0];
    assign index  = bus.cpu_addr[OFF+IDX-1:OFF];
    assign tag    = bus.cpu_addr[WORD_SIZE-1:OFF+IDX];
    assign hit    = valid[index] && (tag_arr[index] == tag);
    assign miss   = (state == IDLE) && bus.cpu_read && !hit;

    // Held in reset the cache looks idle and empty, so the CPU is never stalled by it.
    always_comb begin
        bus.cpu_ready = 1'b1;
        bus.cpu_data  = '0;
        if (reset_n) begin
            if (state == REFILL || miss)
                bus.cpu_ready = 1'b0;
            else if (bus.cpu_read)
                bus.cpu_data = data_arr[index][offset];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            valid        <= '0;
            inv_pending  <= 1'b0;
            bus.mem_read <= 1'b0;
            bus.mem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (invalidate)
                        valid <= '0;
                    if (miss) begin
                        state        <= REFILL;
                        bus.mem_read <= 1'b1;
                        bus.mem_addr <= {bus.cpu_addr[WORD_SIZE-1:OFF], {OFF{1'b0}}};
                    end
                end
                REFILL: begin
                    // An invalidate seen at any point of the refill also discards the line being filled.
                    if (bus.mem_ready) begin
                        if (inv_pending || invalidate)
                            valid <= '0;
                        else
                            valid[index] <= 1'b1;
                        inv_pending  <= 1'b0;
                        bus.mem_read <= 1'b0;
                        state        <= IDLE;
                    end else if (invalidate) begin
                        inv_pending <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The fetch address is held during a refill, so it still names the line being filled.
    always_ff @(posedge clk) begin
        if (state == REFILL && bus.mem_ready) begin
            tag_arr[index] <= tag;
            for (int unsigned k = 0; k < WORDS_PER_LINE; k++)
                data_arr[index][k[OFF-1:0]] <= bus.mem_data[k*WORD_SIZE +: WORD_SIZE];
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (bus.cpu_read && bus.cpu_ready && hit_count != '1)
                hit_count <= hit_count + 1'b1;
            if (miss && miss_count != '1)
                miss_count <= miss_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_dm_param.sv
// Randomized self-checking bench for icache_dm_param against an array-based cache model.
// Counter checks are compiled in only when ICACHE_STATS_EN is defined.
module tb_icache_dm_param;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic invalidate = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    icache_dm_param_if #(.WORD_SIZE(16), .WORDS_PER_LINE(4)) bus ();

    icache_dm_param #(
        .WORD_SIZE(16), .NUM_LINES(8), .WORDS_PER_LINE(4), .STAT_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave),
        .invalidate(invalidate)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    // Behavioural model: backing memory, per-line valid/tag, and event counts.
    logic [15:0] mem_m [0:1023];
    bit          m_valid [8];
    logic [10:0] m_tag [8];
    int unsigned m_hits = 0;
    int unsigned m_misses = 0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic model_flush();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    // One CPU fetch to completion. mode 1: invalidate with the miss; mode 2: invalidate during the first refill.
    task automatic fetch(input logic [15:0] addr, input int unsigned wt, input int unsigned mode);
        int unsigned idx;
        logic [10:0] tg;
        logic [15:0] line;
        bit done;
        idx  = (addr >> 2) % 8;
        tg   = addr[15:5];
        line = addr & 16'hFFFC;
        done = 1'b0;
        for (int att = 0; att < 3 && !done; att++) begin
            @(negedge clk);
            bus.cpu_read  = 1'b1;
            bus.cpu_addr  = addr;
            bus.mem_ready = 1'b0;
            invalidate    = 1'b0;
            if (m_valid[idx] && m_tag[idx] == tg) begin
                #1;
                n_cmp++;
                if (bus.cpu_ready !== 1'b1 || bus.cpu_data !== mem_m[addr] || bus.mem_read !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hit addr=%h: ready=%b data=%h mem_read=%b, required ready=1 data=%h mem_read=0",
                             addr, bus.cpu_ready, bus.cpu_data, bus.mem_read, mem_m[addr]);
                end
                m_hits++;
                done = 1'b1;
            end else begin
                invalidate = (mode == 1 && att == 0);
                #1;
                n_cmp++;
                if (bus.cpu_ready !== 1'b0 || bus.cpu_data !== 16'h0) begin
                    n_fail++;
                    $display("FAIL miss_stall addr=%h: ready=%b data=%h, required ready=0 data=0000",
                             addr, bus.cpu_ready, bus.cpu_data);
                end
                m_misses++;
                if (invalidate) model_flush();
                for (int unsigned w = 0; w <= wt; w++) begin
                    @(negedge clk);
                    invalidate    = (mode == 2 && att == 0 && w == 0);
                    bus.mem_ready = (w == wt);
                    for (int k = 0; k < 4; k++) bus.mem_data[k*16 +: 16] = mem_m[line + k];
                    #1;
                    n_cmp++;
                    if (bus.mem_read !== 1'b1 || bus.mem_addr !== line || bus.cpu_ready !== 1'b0 || bus.cpu_data !== 16'h0) begin
                        n_fail++;
                        $display("FAIL refill addr=%h cyc=%0d: mem_read=%b mem_addr=%h ready=%b data=%h, required 1 %h 0 0000",
                                 addr, w, bus.mem_read, bus.mem_addr, bus.cpu_ready, bus.cpu_data, line);
                    end
                end
                if (mode == 2 && att == 0) model_flush();
                else begin
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = tg;
                end
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL fetch_bound addr=%h: no hit after 3 refills, required a hit", addr);
        end
    endtask

    task automatic flash_invalidate();
        @(negedge clk);
        bus.cpu_read  = 1'b0;
        bus.mem_ready = 1'b0;
        invalidate    = 1'b1;
        #1;
        n_cmp++;
        if (bus.cpu_ready !== 1'b1 || bus.cpu_data !== 16'h0) begin
            n_fail++;
            $display("FAIL idle_inval: ready=%b data=%h, required 1 0000", bus.cpu_ready, bus.cpu_data);
        end
        model_flush();
        @(negedge clk);
        invalidate = 1'b0;
    endtask

    task automatic check_stats(input string name);
`ifdef ICACHE_STATS_EN
        n_cmp++;
        if (hit_count !== 16'(m_hits) || miss_count !== 16'(m_misses)) begin
            n_fail++;
            $display("FAIL stats_%s: hit=%0d miss=%0d, required hit=%0d miss=%0d",
                     name, hit_count, miss_count, m_hits, m_misses);
        end
`else
        if (name.len() == 0) $display("stats name empty");
`endif
    endtask

    task automatic test_reset();
        bus.cpu_read = 1'b0; bus.cpu_addr = '0; bus.mem_ready = 1'b0; bus.mem_data = '0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (bus.cpu_ready !== 1'b1 || bus.cpu_data !== 16'h0 || bus.mem_read !== 1'b0 || bus.mem_addr !== 16'h0) begin
            n_fail++;
            $display("FAIL reset: ready=%b data=%h mem_read=%b mem_addr=%h, required 1 0000 0 0000",
                     bus.cpu_ready, bus.cpu_data, bus.mem_read, bus.mem_addr);
        end
        check_stats("reset");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_cold_miss();
        mem_m[16'h10] = 16'hA000; mem_m[16'h11] = 16'hA001;
        mem_m[16'h12] = 16'hA002; mem_m[16'h13] = 16'hA003;
        fetch(16'h0012, 3, 0);
    endtask

    task automatic test_same_line_hits();
        fetch(16'h0010, 0, 0);
        fetch(16'h0011, 0, 0);
        fetch(16'h0013, 0, 0);
    endtask

    task automatic test_conflict();
        fetch(16'h0092, 1, 0);
        fetch(16'h0012, 0, 0);
    endtask

    task automatic test_invalidate_idle();
        flash_invalidate();
        fetch(16'h0010, 1, 0);
    endtask

    task automatic test_invalidate_refill();
        fetch(16'h0020, 2, 2);
        fetch(16'h0034, 1, 1);
        fetch(16'h0035, 0, 0);
        check_stats("directed");
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            int unsigned r;
            r = $urandom_range(0, 11);
            if (r == 0) flash_invalidate();
            else fetch(16'($urandom_range(0, 255)), $urandom_range(0, 3),
                       (r == 1) ? 1 : (r == 2) ? 2 : 0);
        end
        check_stats("random");
    endtask

    task automatic test_reset_mid_refill();
        @(negedge clk);
        bus.cpu_read = 1'b1; bus.cpu_addr = 16'h0350; bus.mem_ready = 1'b0; invalidate = 1'b0;
        model_flush();
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL refill_start: mem_read=%b, required 1", bus.mem_read);
        end
        reset_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (bus.mem_read !== 1'b0 || bus.cpu_ready !== 1'b1 || bus.cpu_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid_refill: mem_read=%b ready=%b data=%h, required 0 1 0000",
                     bus.mem_read, bus.cpu_ready, bus.cpu_data);
        end
        check_stats("mid_reset");
        bus.cpu_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        fetch(16'h0040, 2, 0);
        fetch(16'h0041, 0, 0);
        fetch(16'h0042, 0, 0);
        check_stats("after_reset");
        @(negedge clk);
        bus.cpu_read = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_m[i] = 16'($urandom);
        test_reset();
        test_cold_miss();
        test_same_line_hits();
        test_conflict();
        test_invalidate_idle();
        test_invalidate_refill();
        test_random();
        test_reset_mid_refill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
